// File: rtl/prio_sel_change_fifo.sv
// Priority-selected byte register with change detection; each new held value is
// queued in a small FWFT FIFO that drains over a valid/ready stream, with saturating statistics.
module prio_sel_change_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CONST_VAL = 1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         c,
    input  logic                     s1,
    input  logic                     s2,
    output logic [WIDTH-1:0]         held_out,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         chg_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] CONST_V  = WIDTH'(CONST_VAL);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] next_val;
    logic             chg;
    logic             pop;
    logic             push;
    logic             drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    assign full    = (fifo_count == FULL_CNT);
    assign empty   = (fifo_count == '0);
    assign m_valid = !empty;
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    // A pop in the same edge frees the slot, so a change event while full is only lost without one.
    always_comb begin
        next_val = held_out;
        if (s1)      next_val = c;
        else if (s2) next_val = CONST_V;
        chg  = (next_val != held_out);
        pop  = m_valid && m_ready;
        push = chg && (!full || pop);
        drop = chg && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_out   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            chg_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            held_out <= next_val;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            chg_cnt  <= sat_inc(chg_cnt, chg);
            drop_cnt <= sat_inc(drop_cnt, drop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= next_val;
    end

endmodule

// File: tb/tb_prio_sel_change_fifo.sv
// Directed bench for prio_sel_change_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the end of each scenario.
module tb_prio_sel_change_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] c;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] held_out;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [2:0]       fifo_count;
    logic             full;
    logic             empty;
    logic [15:0]      chg_cnt;
    logic [15:0]      drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    prio_sel_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CONST_VAL(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .c(c), .s1(s1), .s2(s2), .held_out(held_out),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .fifo_count(fifo_count),
        .full(full), .empty(empty), .chg_cnt(chg_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus counters.
    logic [7:0] q[$];
    logic [7:0] m_held;
    int         m_chg;
    int         m_drop;
    bit         started = 0;

    always @(posedge clk) begin
        logic [7:0] nxt;
        if (rst) begin
            q.delete();
            m_held  = 8'h00;
            m_chg   = 0;
            m_drop  = 0;
            started = 1;
        end else if (started) begin
            nxt = s1 ? c : (s2 ? 8'h01 : m_held);
            if (m_ready && q.size() > 0) void'(q.pop_front());
            if (nxt != m_held) begin
                if (m_chg < 65535) m_chg++;
                if (q.size() < DEPTH) q.push_back(nxt);
                else if (m_drop < 65535) m_drop++;
            end
            m_held = nxt;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("held_out",   held_out,   m_held);
            chk("m_valid",    m_valid,    q.size() > 0);
            chk("m_data",     m_data,     (q.size() > 0) ? q[0] : 8'h00);
            chk("fifo_count", fifo_count, q.size());
            chk("full",       full,       q.size() == DEPTH);
            chk("empty",      empty,      q.size() == 0);
            chk("chg_cnt",    chg_cnt,    m_chg);
            chk("drop_cnt",   drop_cnt,   m_drop);
        end
    end

    // Apply inputs at a falling edge, then let exactly one rising edge pass.
    task automatic drive(input logic r, input logic a1, input logic a2,
                         input logic [7:0] cc, input logic rdy);
        rst = r; s1 = a1; s2 = a2; c = cc; m_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; s1 = 1'b0; s2 = 1'b0; c = 8'h00; m_ready = 1'b0;

        // Reset and priority
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 1, 1, 8'h77, 1);
        chk("rst_held", held_out, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_mdata", m_data, 8'h00);
        drive(0, 1, 0, 8'h5A, 0);
        chk("sel_held", held_out, 8'h5A);
        chk("sel_mvalid", m_valid, 1'b1);
        chk("sel_mdata", m_data, 8'h5A);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 0);
        chk("hold_held", held_out, 8'h5A);
        chk("hold_count", fifo_count, 3'd1);
        chk("hold_chg", chg_cnt, 16'd1);
        drive(0, 0, 0, 8'h00, 1);
        chk("drain1_empty", empty, 1'b1);

        // Priority and equality
        drive(0, 1, 1, 8'h33, 0);
        chk("both_held", held_out, 8'h33);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h00, 0);
        chk("const_held", held_out, 8'h01);
        chk("const_count", fifo_count, 3'd2);
        chk("const_chg", chg_cnt, 16'd3);
        chk("const_head", m_data, 8'h33);
        drive(0, 0, 0, 8'h00, 1);
        chk("const_head2", m_data, 8'h01);
        drive(0, 0, 0, 8'h00, 1);
        chk("const_empty", empty, 1'b1);

        // Fill and drop
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'h10 + 8'(i), 0);
            if (i == 3) begin
                chk("fill_full", full, 1'b1);
                chk("fill_count", fifo_count, 3'd4);
            end
        end
        chk("drop_cnt", drop_cnt, 16'd2);
        chk("drop_chg", chg_cnt, 16'd9);
        chk("drop_held", held_out, 8'h15);
        chk("drop_head", m_data, 8'h10);

        // Simultaneous push and pop at full
        drive(0, 1, 0, 8'h20, 1);
        chk("pp_count", fifo_count, 3'd4);
        chk("pp_drop", drop_cnt, 16'd2);
        chk("pp_head", m_data, 8'h11);

        // Drain and empty, across the pointer wrap
        chk("drain_a", m_data, 8'h11);
        drive(0, 0, 0, 8'h00, 1);
        chk("drain_b", m_data, 8'h12);
        drive(0, 0, 0, 8'h00, 1);
        chk("drain_c", m_data, 8'h13);
        drive(0, 0, 0, 8'h00, 1);
        chk("drain_d", m_data, 8'h20);
        drive(0, 0, 0, 8'h00, 1);
        chk("drain_mvalid", m_valid, 1'b0);
        chk("drain_mdata", m_data, 8'h00);
        chk("drain_empty", empty, 1'b1);
        drive(0, 0, 0, 8'h00, 1);
        chk("idle_ready_count", fifo_count, 3'd0);

        // Reset mid-operation
        drive(0, 1, 0, 8'hA1, 0);
        drive(0, 1, 0, 8'hA2, 0);
        drive(0, 1, 0, 8'hA3, 0);
        chk("pre_rst_count", fifo_count, 3'd3);
        drive(1, 1, 0, 8'hFF, 1);
        chk("mid_rst_held", held_out, 8'h00);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_chg", chg_cnt, 16'd0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        drive(0, 0, 0, 8'h00, 0);
        chk("post_rst_held", held_out, 8'h00);
        chk("post_rst_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
